// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit: size encodings, FSM states,
// default timeout, and store lane helpers (big-endian: lane 0 is bits 31:24).
package mem_access_pkg;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    SzWord = 2'b00,
    SzByte = 2'b01,
    SzHalf = 2'b10,
    SzNone = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  // Byte enables for an access; loads always read the full word.
  function automatic logic [3:0] lane_be(input logic is_store, input size_e sz,
                                         input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      unique case (sz)
        SzHalf:  be = lane[1] ? 4'b0011 : 4'b1100;
        SzByte:  be = 4'b1000 >> lane;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replicate right-justified store data across every lane it could occupy.
  function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] wd);
    logic [31:0] d;
    unique case (sz)
      SzHalf:  d = {2{wd[15:0]}};
      SzByte:  d = {4{wd[7:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_ld_extract.sv
// Combinational load lane extraction with sign or zero extension (big-endian lanes).
module ld_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane, then extend it to 32 bits.
  always_comb begin
    byte_v = 8'h00;
    half_v = 16'h0000;
    data_o = '0;
    unique case (lane_i)
      2'b00: byte_v = rdata_i[31:24];
      2'b01: byte_v = rdata_i[23:16];
      2'b10: byte_v = rdata_i[15:8];
      2'b11: byte_v = rdata_i[7:0];
    endcase
    half_v = lane_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    unique case (size_i)
      SzWord:  data_o = rdata_i;
      SzHalf:  data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      SzByte:  data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a core and a simple word-addressed ack-based memory bus.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- misaligned half/word requests complete
// immediately with misalign=1 instead of being forced onto an aligned address.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  size_e       size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

  size_e       size_in;
  logic [1:0]  lane_in;
  logic        mis_in;
  logic [31:0] ld_data;

  assign size_in = size_e'(size);

  // Force the unused low address bits of a half or word access to zero.
  always_comb begin
    lane_in = addr[1:0];
    unique case (size_in)
      SzWord:  lane_in = 2'b00;
      SzHalf:  lane_in = {addr[1], 1'b0};
      default: lane_in = addr[1:0];
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = ((size_in == SzHalf) && addr[0]) || ((size_in == SzWord) && (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  ld_extract u_ld_extract (
    .rdata_i    (mem_rdata),
    .size_i     (size_q),
    .lane_i     (lane_q),
    .unsigned_i (unsigned_q),
    .data_o     (ld_data)
  );

  // Next-state logic for the IDLE -> BUS -> RESP sequence and all registered outputs.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          is_store_d = is_store;
          size_d     = size_in;
          unsigned_d = unsigned_ld;
          lane_d     = lane_in;
          rdata_d    = '0;
          misalign_d = 1'b0;
          bus_err_d  = 1'b0;
          if (size_in == SzNone || mis_in) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            misalign_d   = mis_in;
          end else begin
            state_d     = StBus;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_be_d    = lane_be(is_store, size_in, lane_in);
            mem_addr_d  = addr[31:2];
            mem_wdata_d = store_data(size_in, wdata);
          end
        end
      end
      StBus: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack || (cnt_q + 8'd1 == TimeoutCnt)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = '0;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          if (mem_ack) begin
            rdata_d = is_store_q ? 32'h0 : ld_data;
          end else begin
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any bus access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      size_q       <= SzWord;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the bench plays the memory side by hand.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .is_store    (is_store),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .resp_valid  (resp_valid),
    .rdata       (rdata),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns one cycle after acceptance.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    is_store = st; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst req_ready got=%0b exp=1", req_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst mem_req got=%0b exp=0", mem_req); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst resp_valid got=%0b exp=0", resp_valid); end
    total++; if ({mem_be, mem_addr, mem_wdata, rdata} !== 98'h0) begin bad++; $display("FAIL rst buses got be=%h a=%h wd=%h rd=%h exp=0", mem_be, mem_addr, mem_wdata, rdata); end
    total++; if ({misalign, bus_err, mem_we} !== 3'b000) begin bad++; $display("FAIL rst flags got=%b exp=000", {misalign, bus_err, mem_we}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_loads();
    logic [31:0] va [6] = '{32'h1003, 32'h1003, 32'h1000, 32'h1002, 32'h1000, 32'h1004};
    logic [1:0]  vs [6] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    logic        vu [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] vr [6] = '{32'hF0, 32'hF0, 32'h7F0000AA, 32'h12348765, 32'h87651234, 32'hDEADBEEF};
    logic [29:0] vw [6] = '{30'h400, 30'h400, 30'h400, 30'h400, 30'h400, 30'h401};
    logic [31:0] ve [6] = '{32'hFFFFFFF0, 32'hF0, 32'h7F, 32'hFFFF8765, 32'h8765, 32'hDEADBEEF};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, vs[i], vu[i], va[i], 32'h0);
      total++; if ({mem_req, mem_we, mem_be} !== 6'b101111) begin bad++; $display("FAIL load%0d req/we/be got=%b exp=101111", i, {mem_req, mem_we, mem_be}); end
      total++; if (mem_addr !== vw[i]) begin bad++; $display("FAIL load%0d mem_addr got=%h exp=%h", i, mem_addr, vw[i]); end
      step();  // ack arrives in the second BUS cycle
      mem_ack = 1'b1; mem_rdata = vr[i];
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      total++; if ({resp_valid, mem_req, bus_err, misalign} !== 4'b1000) begin bad++; $display("FAIL load%0d resp flags got=%b exp=1000", i, {resp_valid, mem_req, bus_err, misalign}); end
      total++; if (rdata !== ve[i]) begin bad++; $display("FAIL load%0d rdata got=%h exp=%h", i, rdata, ve[i]); end
      step();
      total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL load%0d after resp got=%b exp=01", i, {resp_valid, req_ready}); end
      total++; if (rdata !== ve[i]) begin bad++; $display("FAIL load%0d rdata hold got=%h exp=%h", i, rdata, ve[i]); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] va [3] = '{32'h2002, 32'h2001, 32'h2000};
    logic [1:0]  vs [3] = '{2'b10, 2'b01, 2'b10};
    logic [31:0] vd [3] = '{32'h0000ABCD, 32'h00000055, 32'h00001234};
    logic [3:0]  vb [3] = '{4'b0011, 4'b0100, 4'b1100};
    logic [31:0] vx [3] = '{32'hABCDABCD, 32'h55555555, 32'h12341234};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, vs[i], 1'b0, va[i], vd[i]);
      total++; if ({mem_req, mem_we} !== 2'b11) begin bad++; $display("FAIL store%0d req/we got=%b exp=11", i, {mem_req, mem_we}); end
      total++; if (mem_be !== vb[i]) begin bad++; $display("FAIL store%0d mem_be got=%b exp=%b", i, mem_be, vb[i]); end
      total++; if (mem_wdata !== vx[i]) begin bad++; $display("FAIL store%0d mem_wdata got=%h exp=%h", i, mem_wdata, vx[i]); end
      total++; if (mem_addr !== 30'h800) begin bad++; $display("FAIL store%0d mem_addr got=%h exp=800", i, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      total++; if ({resp_valid, rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL store%0d resp got v=%0b rd=%h exp v=1 rd=0", i, resp_valid, rdata); end
      step();
    end
  endtask

  task automatic test_size_none();
    issue(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
    total++; if ({resp_valid, mem_req, misalign, bus_err} !== 4'b1000) begin bad++; $display("FAIL none flags got=%b exp=1000", {resp_valid, mem_req, misalign, bus_err}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL none rdata got=%h exp=0", rdata); end
    step();
    total++; if ({resp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL none after got=%b exp=01", {resp_valid, req_ready}); end
  endtask

  task automatic test_misalign();
    issue(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    total++; if ({resp_valid, misalign, mem_req} !== 3'b110) begin bad++; $display("FAIL mis trap got=%b exp=110", {resp_valid, misalign, mem_req}); end
    step();
`else
    total++; if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1111, 30'h400}) begin bad++; $display("FAIL mis bus got req=%0b be=%b a=%h exp 1 1111 400", mem_req, mem_be, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h8001FFFF;
    step();
    mem_ack = 1'b0;
    total++; if ({resp_valid, misalign, rdata} !== {2'b10, 32'hFFFF8001}) begin bad++; $display("FAIL mis resp got v=%0b m=%0b rd=%h exp 1 0 ffff8001", resp_valid, misalign, rdata); end
    step();
`endif
  endtask

  task automatic test_timeout();
    issue(1'b0, 2'b00, 1'b0, 32'h3000, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      total++; if ({mem_req, resp_valid} !== 2'b10) begin bad++; $display("FAIL tmo bus%0d got=%b exp=10", c, {mem_req, resp_valid}); end
      step();
    end
    total++; if ({mem_req, resp_valid, bus_err} !== 3'b011) begin bad++; $display("FAIL tmo resp got=%b exp=011", {mem_req, resp_valid, bus_err}); end
    step();
    total++; if ({resp_valid, bus_err, req_ready} !== 3'b011) begin bad++; $display("FAIL tmo hold got=%b exp=011", {resp_valid, bus_err, req_ready}); end
    // Ack in the very cycle the count expires is treated as a normal completion.
    issue(1'b0, 2'b00, 1'b0, 32'h3000, 32'h0);
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL tmo clear bus_err got=%0b exp=0", bus_err); end
    step(); step(); step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    total++; if ({resp_valid, bus_err, rdata} !== {2'b10, 32'hCAFEF00D}) begin bad++; $display("FAIL tmo edge got v=%0b e=%0b rd=%h exp 1 0 cafef00d", resp_valid, bus_err, rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    issue(1'b0, 2'b00, 1'b0, 32'h6000, 32'h0);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid pre mem_req got=%0b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, resp_valid, req_ready} !== 3'b001) begin bad++; $display("FAIL rstmid got=%b exp=001", {mem_req, resp_valid, req_ready}); end
    #2 rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_ack = 1'b0;
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    total++; if ({seen, mem_req, req_ready} !== 3'b001) begin bad++; $display("FAIL rstmid after got=%b exp=001", {seen, mem_req, req_ready}); end
  endtask

  task automatic test_back_to_back();
    is_store = 1'b0; size = 2'b00; unsigned_ld = 1'b0; addr = 32'h4000; wdata = 32'h0;
    req_valid = 1'b1;
    step();
    is_store = 1'b1; addr = 32'h5000; wdata = 32'h11223344;
    total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 30'h1000}) begin bad++; $display("FAIL b2b first got req=%0b we=%0b a=%h exp 1 0 1000", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
    step();
    mem_ack = 1'b0;
    total++; if ({resp_valid, req_ready, rdata} !== {2'b10, 32'h0BADBEEF}) begin bad++; $display("FAIL b2b resp got v=%0b rdy=%0b rd=%h exp 1 0 0badbeef", resp_valid, req_ready, rdata); end
    step();
    total++; if ({resp_valid, req_ready, mem_req} !== 3'b010) begin bad++; $display("FAIL b2b idle got=%b exp=010", {resp_valid, req_ready, mem_req}); end
    step();
    req_valid = 1'b0;
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 30'h1400, 32'h11223344}) begin bad++; $display("FAIL b2b second got req=%0b we=%0b a=%h wd=%h", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if ({resp_valid, rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL b2b second resp got v=%0b rd=%h exp 1 0", resp_valid, rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_size_none();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
